mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter for the pipeline's single-ported, fixed-latency unified memory. It sits between the fetch stage (instruction port) and the memory stage (data port) and owns the memory interface. It serializes accesses, with the data port taking priority over the instruction port, and generates per-port stall signals for the pipeline. It also keeps saturating grant counters for the perf log.

## Interface
- `ADDR_W`, default 16: address width.
- `DATA_W`, default 16: data width.
- `MEM_LAT`, default 4: memory read latency in cycles from the `mem_en` cycle; must be ≥1.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `i_req`  in  1  instruction fetch request; level signal, held until `i_done`.
- `i_addr`  in  ADDR_W  fetch address; stable while `i_req` is high.
- `i_rdata`  out  DATA_W  fetched word; registered, valid when `i_done` is high.
- `i_done`  out  1  one-cycle completion pulse.
- `i_stall`  out  1  `i_req & ~i_done`.
- `d_req`  in  1  data request; level signal, held until `d_done`.
- `d_wr`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_rdata`  out  DATA_W  load data; registered, updated on loads only.
- `d_done`  out  1  one-cycle completion pulse.
- `d_stall`  out  1  `d_req & ~d_done`.
- `mem_en`  out  1  one-cycle memory access strobe.
- `mem_wr`  out  1  write enable; qualified by `mem_en`.
- `mem_addr`  out  ADDR_W  latched address.
- `mem_wdata`  out  DATA_W  latched write data.
- `mem_rdata`  in  DATA_W  valid exactly MEM_LAT cycles after the `mem_en` cycle.
- `i_grant_cnt`  out  16  instruction grants; saturates at 0xFFFF.
- `d_grant_cnt`  out  16  data grants; saturates at 0xFFFF.

## Operation
- States:
  - `IDLE`
  - `ISSUE` (`mem_en` high)
  - `WAIT` (latency countdown)
- The owner (I or D) is latched at grant.
- In `IDLE`:
  - If `d_req` is high and not completing this cycle, latch `d_addr`, `d_wdata` and `d_wr`, set owner=D, go to `ISSUE`.
  - Otherwise, if `i_req` is high and not completing, latch `i_addr`, set `mem_wr`=0, owner=I, go to `ISSUE`.
  - Otherwise stay in `IDLE`.
- "Completing" means that port's `x_done` is high in the current cycle. Its `req` is still high then and must be ignored.
- `ISSUE`: drive `mem_en`=1 for this cycle only, load counter=MEM_LAT-1, go to `WAIT`.
- `WAIT`: decrement the counter each cycle. When counter==0 (this is the cycle `mem_rdata` is valid):
  - Register `mem_rdata` into the owner's rdata. Skip this for D-writes; `d_rdata` holds its old value.
  - Set the owner's done for the next cycle and go to `IDLE`.
- With MEM_LAT=1, `WAIT` lasts one cycle with counter==0.
- On a grant, the matching grant counter increments, saturating at 0xFFFF.
- Both requests present in `IDLE`: D wins; I is granted after D completes.
- A request deasserted mid-access (protocol violation) does not abort the access; done still pulses.
- `mem_addr`, `mem_wdata` and `mem_wr` hold their latched values until the next grant. `mem_wr` is zeroed on instruction grants.

## Timing
- A request first seen in `IDLE` in cycle 0 gives `mem_en` in cycle 1 and `mem_rdata` sampled in cycle 1+MEM_LAT.
- `x_done` and `x_rdata` are visible in cycle MEM_LAT+2. Default latency is 6 cycles.
- Back-to-back throughput is one access per MEM_LAT+2 cycles. The next grant can be decided in the done cycle, giving `mem_en` in cycle MEM_LAT+3.
- The stall outputs are combinational from `req` and the registered done.
- Reset (async, any state including mid-`WAIT`) clears, effective immediately:
  - state→`IDLE`, counter→0
  - `mem_en`, `mem_wr`, `i_done`, `d_done`→0
  - `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata`→0
  - both grant counters→0
- No done pulse is produced for an access aborted by reset.
- Counter width is $clog2(MEM_LAT+1).

## Structure
- `mem_arb_pkg` holds:
  - the state enum (`IDLE`, `ISSUE`, `WAIT`)
  - the owner enum (`OWN_I`, `OWN_D`)
  - the `GRANT_CNT_W`=16 constant
- Sub-module `mem_arb_sat_cnt`: 16-bit saturating counter with async reset and `inc` input, instanced twice.

## Test plan
- Single load, `d_addr`=0x0040, `mem_rdata`=0xBEEF valid in cycle 5: `mem_en` high in cycle 1 only, `mem_wr`=0, `d_done` and `d_rdata`=0xBEEF in cycle 6, `d_stall` high in cycles 0–5. `d_grant_cnt`=1.
- Simultaneous `i_req`(0x0000) and `d_req` store(0x0010, 0x1234) in cycle 0:
  - D served first: `mem_en`, `mem_wr`=1 with 0x0010/0x1234 in cycle 1, `d_done` cycle 6, `d_rdata` unchanged.
  - I served next: `mem_en` cycle 7, `i_done` cycle 12.
- Fetch with `i_req` held through `i_done`: no duplicate grant. The next `mem_en` occurs only if `i_req` is still high after the done cycle.
- Reset asserted asynchronously in cycle 3 of an access: all outputs go to 0 without waiting for a clock edge. No done pulse follows; after release, a new request completes normally.
- MEM_LAT=1 parameterization: load completes with done in cycle 3.
- 65536+ grants: `i_grant_cnt` saturates at 0xFFFF and stays there.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   owner_e     : which port owns the access in flight
//   GRANT_CNT_W : width of the perf-log grant counters
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int GRANT_CNT_W = 16;

endpackage

// File: rtl/mem_arb_sat_cnt.sv
// Saturating up-counter used for the per-port grant statistics.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count one event this cycle
//   cnt      : current count; sticks at all-ones
module mem_arb_sat_cnt
  import mem_arb_pkg::*;
#(
  parameter int W = GRANT_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported, fixed-latency memory.
// The data port wins over the instruction port; accesses are fully
// serialized (one in flight at a time).
//   clk, rst                  : clock, asynchronous active-high reset
//   i_req/i_addr              : fetch request (level, held until i_done)
//   i_rdata/i_done/i_stall    : fetch response, done pulse, pipeline stall
//   d_req/d_wr/d_addr/d_wdata : load/store request (level, held until d_done)
//   d_rdata/d_done/d_stall    : load data (loads only), done pulse, stall
//   mem_en/mem_wr/mem_addr/mem_wdata/mem_rdata : memory interface
//   i_grant_cnt/d_grant_cnt   : saturating grant counters
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = GRANT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  arb_state_e    state;
  owner_e        owner;
  logic [CW-1:0] cnt;
  logic          grant_i, grant_d;

  // A port whose done is high this cycle still has req asserted for the
  // finished access; masking it prevents a duplicate grant.
  always_comb begin
    grant_d = (state == IDLE) && d_req && !d_done;
    grant_i = (state == IDLE) && i_req && !i_done && !grant_d;
  end

  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_I;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
    end else begin
      // strobes are single-cycle unless re-asserted below
      mem_en <= 1'b0;
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wr    <= d_wr;
            owner     <= OWN_D;
            mem_en    <= 1'b1;
            state     <= ISSUE;
          end else if (grant_i) begin
            // mem_wdata keeps its last store value; only mem_wr matters
            mem_addr <= i_addr;
            mem_wr   <= 1'b0;
            owner    <= OWN_I;
            mem_en   <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CNT_INIT;
          state <= WAIT;
        end
        WAIT: begin
          // cnt==0 marks the cycle mem_rdata is valid
          if (cnt == '0) begin
            if (owner == OWN_D) begin
              d_done <= 1'b1;
              if (!mem_wr) d_rdata <= mem_rdata;
            end else begin
              i_done  <= 1'b1;
              i_rdata <= mem_rdata;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_arb_sat_cnt #(.W(CNT_W)) u_i_cnt (
    .clk (clk),
    .rst (rst),
    .inc (grant_i),
    .cnt (i_grant_cnt)
  );

  mem_arb_sat_cnt #(.W(CNT_W)) u_d_cnt (
    .clk (clk),
    .rst (rst),
    .inc (grant_d),
    .cnt (d_grant_cnt)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing checks, an async-reset abort,
// a randomized two-port phase against a reference memory model, and a
// MEM_LAT=1 / narrow-counter instance for latency and saturation.
module tb_mem_arbiter;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT 1: default parameters ----------------
  logic        i_req, d_req, d_wr, i_done, d_done, i_stall, d_stall;
  logic [15:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] i_grant_cnt, d_grant_cnt;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  // ---------------- DUT 2: MEM_LAT=1, 4-bit counters ----------------
  logic        i_req2, d_req2, d_wr2, i_done2, d_done2, i_stall2, d_stall2;
  logic [15:0] i_addr2, d_addr2, d_wdata2, i_rdata2, d_rdata2;
  logic        mem_en2, mem_wr2;
  logic [15:0] mem_addr2, mem_wdata2, mem_rdata2;
  logic [3:0]  i_grant_cnt2, d_grant_cnt2;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst),
    .i_req(i_req2), .i_addr(i_addr2), .i_rdata(i_rdata2), .i_done(i_done2), .i_stall(i_stall2),
    .d_req(d_req2), .d_wr(d_wr2), .d_addr(d_addr2), .d_wdata(d_wdata2),
    .d_rdata(d_rdata2), .d_done(d_done2), .d_stall(d_stall2),
    .mem_en(mem_en2), .mem_wr(mem_wr2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .i_grant_cnt(i_grant_cnt2), .d_grant_cnt(d_grant_cnt2)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int c0    = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0040) ? 16'hBEEF : ((a * 16'h9E37) ^ 16'h5A5A);
  endfunction

  assign mem_rdata2 = init_val(mem_addr2);

  // physical memory behind DUT 1, and the reference view the stimulus uses
  logic [15:0] phys    [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];

  function automatic logic [15:0] phys_rd(input logic [15:0] a);
    return phys.exists(a) ? phys[a] : init_val(a);
  endfunction
  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  typedef struct { int due; logic [15:0] data; } rd_t;
  rd_t pend[$];

  // Memory: read data appears only in its due cycle, noise otherwise.
  always @(negedge clk) begin
    mem_rdata = 16'($urandom);
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mem_rdata = pend[0].data;
      void'(pend.pop_front());
    end
    if (mem_en) begin
      if (mem_wr) phys[mem_addr] = mem_wdata;
      else        pend.push_back('{cyc + LAT, phys_rd(mem_addr)});
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [15:0] data; logic wr; int cnt; } exp_t;
  exp_t iq[$];
  exp_t dq[$];
  exp_t ie, de;
  int   icnt = 0, dcnt = 0;
  logic [15:0] d_last = 16'h0;
  int   en_log[$], idone_log[$], ddone_log[$];
  int   exq[$];
  logic cmd_ok;

  task automatic issue_i(input logic [15:0] a);
    i_addr = a;
    i_req  = 1'b1;
    icnt++;
    iq.push_back('{ref_rd(a), 1'b0, icnt});
  endtask

  task automatic issue_d(input logic wr, input logic [15:0] a, input logic [15:0] wd);
    d_wr    = wr;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    dcnt++;
    if (wr) ref_mem[a] = wd;
    else    d_last = ref_rd(a);
    dq.push_back('{d_last, wr, dcnt});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (i_done) begin
        idone_log.push_back(cyc);
        if (iq.size() == 0) chk("i_spurious_done", {31'b0, i_done}, 0);
        else begin
          ie = iq.pop_front();
          chk("i_rdata", {16'b0, i_rdata}, {16'b0, ie.data});
          chk("i_grant_cnt", {16'b0, i_grant_cnt}, ie.cnt);
        end
      end
      if (d_done) begin
        ddone_log.push_back(cyc);
        if (dq.size() == 0) chk("d_spurious_done", {31'b0, d_done}, 0);
        else begin
          de = dq.pop_front();
          chk(de.wr ? "d_rdata_after_store" : "d_rdata", {16'b0, d_rdata}, {16'b0, de.data});
          chk("d_grant_cnt", {16'b0, d_grant_cnt}, de.cnt);
        end
      end
      if (mem_en) begin
        en_log.push_back(cyc);
        cmd_ok = mem_wr ? (d_req && d_wr && mem_addr == d_addr && mem_wdata == d_wdata)
                        : ((i_req && mem_addr == i_addr) || (d_req && !d_wr && mem_addr == d_addr));
        chk("mem_cmd", {31'b0, cmd_ok}, 1);
      end
    end
  end

  task automatic clr_logs();
    en_log.delete(); idone_log.delete(); ddone_log.delete();
  endtask

  task automatic chk_log(input string n, input int q[$], input int ex[$]);
    chk({n, "_count"}, q.size(), ex.size());
    for (int j = 0; j < q.size() && j < ex.size(); j++) chk(n, q[j] - c0, ex[j]);
  endtask

  task automatic begin_test();
    @(posedge clk); #1;
    c0 = cyc;
    clr_logs();
  endtask

  task automatic wait_done_i();
    int t = 0;
    do begin @(negedge clk); t++; end while (!i_done && t < 100);
    if (!i_done) chk("i_done_timeout", {31'b0, i_done}, 1);
    #1 i_req = 1'b0;
  endtask

  task automatic wait_done_d();
    int t = 0;
    do begin @(negedge clk); t++; end while (!d_done && t < 100);
    if (!d_done) chk("d_done_timeout", {31'b0, d_done}, 1);
    #1 d_req = 1'b0;
  endtask

  task automatic rand_i(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      @(posedge clk); #1;
      issue_i(16'($urandom_range(0, 255)));
      wait_done_i();
    end
  endtask

  task automatic rand_d(input int n);
    logic        wr;
    logic [15:0] a;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      @(posedge clk); #1;
      wr = 1'($urandom_range(0, 1));
      if (wr || $urandom_range(0, 1) == 1) a = 16'h1000 + 16'($urandom_range(0, 15));
      else                                 a = 16'($urandom_range(0, 255));
      issue_d(wr, a, 16'($urandom));
      wait_done_d();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_req = 0; d_req = 0; d_wr = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    i_req2 = 0; d_req2 = 0; d_wr2 = 0; i_addr2 = 0; d_addr2 = 0; d_wdata2 = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_en", {31'b0, mem_en}, 0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 0);
    chk("rst_i_done", {31'b0, i_done}, 0);
    chk("rst_d_done", {31'b0, d_done}, 0);
    chk("rst_i_rdata", {16'b0, i_rdata}, 0);
    chk("rst_i_grant_cnt", {16'b0, i_grant_cnt}, 0);
    chk("rst_d_grant_cnt", {16'b0, d_grant_cnt}, 0);
    rst = 1'b0;

    // single load, data 0xBEEF due in cycle 5
    begin_test();
    issue_d(1'b0, 16'h0040, 16'h0);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk("t1_d_stall", {31'b0, d_stall}, (k <= 5) ? 1 : 0);
      chk("t1_d_done", {31'b0, d_done}, (k == 6) ? 1 : 0);
      if (k == 1) chk("t1_mem_wr", {31'b0, mem_wr}, 0);
      if (k == 6) chk("t1_d_rdata", {16'b0, d_rdata}, 32'hBEEF);
    end
    #1 d_req = 1'b0;
    repeat (3) @(negedge clk);
    exq = {1}; chk_log("t1_mem_en", en_log, exq);
    chk("t1_d_grant_cnt", {16'b0, d_grant_cnt}, 1);

    // simultaneous fetch and store: D first, then I
    begin_test();
    issue_i(16'h0000);
    issue_d(1'b1, 16'h0010, 16'h1234);
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      chk("t2_i_stall", {31'b0, i_stall}, (k < 12) ? 1 : 0);
      if (k == 1) begin
        chk("t2_store_wr", {31'b0, mem_wr}, 1);
        chk("t2_store_addr", {16'b0, mem_addr}, 32'h0010);
        chk("t2_store_wdata", {16'b0, mem_wdata}, 32'h1234);
      end
      if (k == 6) begin
        chk("t2_d_rdata_held", {16'b0, d_rdata}, 32'hBEEF);
        #1 d_req = 1'b0;
      end
      if (k == 7) begin
        chk("t2_fetch_wr", {31'b0, mem_wr}, 0);
        chk("t2_fetch_addr", {16'b0, mem_addr}, 0);
      end
      if (k == 12) #1 i_req = 1'b0;
    end
    exq = {1, 7};  chk_log("t2_mem_en", en_log, exq);
    exq = {6};     chk_log("t2_d_done", ddone_log, exq);
    exq = {12};    chk_log("t2_i_done", idone_log, exq);

    // fetch held through done: second fetch only because req stays high
    begin_test();
    issue_i(16'h0020);
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      if (k == 6) #1 issue_i(16'h0021);
      if (k == 13) #1 i_req = 1'b0;
    end
    exq = {1, 8};  chk_log("t3_mem_en", en_log, exq);
    exq = {6, 13}; chk_log("t3_i_done", idone_log, exq);

    // async reset in cycle 3 of a load
    begin_test();
    issue_d(1'b0, 16'h0040, 16'h0);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("ar_mem_addr", {16'b0, mem_addr}, 0);
    chk("ar_mem_wdata", {16'b0, mem_wdata}, 0);
    chk("ar_d_rdata", {16'b0, d_rdata}, 0);
    chk("ar_i_rdata", {16'b0, i_rdata}, 0);
    chk("ar_i_grant_cnt", {16'b0, i_grant_cnt}, 0);
    chk("ar_d_grant_cnt", {16'b0, d_grant_cnt}, 0);
    d_req = 1'b0;
    pend.delete(); dq.delete(); iq.delete();
    d_last = 16'h0; icnt = 0; dcnt = 0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    begin_test();
    repeat (10) @(negedge clk);
    chk("ar_no_done", ddone_log.size(), 0);
    chk("ar_no_mem_en", en_log.size(), 0);
    begin_test();
    issue_d(1'b0, 16'h0040, 16'h0);
    wait_done_d();
    exq = {6}; chk_log("ar_after_done", ddone_log, exq);

    // randomized traffic on both ports
    fork
      rand_i(30);
      rand_d(30);
    join
    repeat (10) @(negedge clk);
    chk("rand_i_drained", iq.size(), 0);
    chk("rand_d_drained", dq.size(), 0);

    // MEM_LAT=1 instance: load done in cycle 3
    begin_test();
    d_addr2 = 16'h0040; d_wr2 = 1'b0; d_req2 = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      chk("l1_d_done", {31'b0, d_done2}, (k == 3) ? 1 : 0);
      if (k == 3) chk("l1_d_rdata", {16'b0, d_rdata2}, 32'hBEEF);
    end
    #1 d_req2 = 1'b0;

    // held fetch: grant every 4 cycles, 4-bit counter saturates at 15
    begin_test();
    i_addr2 = 16'h0005; i_req2 = 1'b1;
    repeat (10) @(negedge clk);
    chk("sat_partial", {28'b0, i_grant_cnt2}, 3);
    repeat (80) @(negedge clk);
    chk("sat_reached", {28'b0, i_grant_cnt2}, 15);
    chk("sat_i_rdata", {16'b0, i_rdata2}, {16'b0, init_val(16'h0005)});
    repeat (20) @(negedge clk);
    chk("sat_held", {28'b0, i_grant_cnt2}, 15);
    chk("sat_d_cnt", {28'b0, d_grant_cnt2}, 1);
    i_req2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
